pulse_param_rx: RTL and testbench

Serial command receiver that sets up the pulse generator's timing parameters. It receives 8N1 UART bytes on `rxd`, parses fixed 7-byte write frames, checks each frame's checksum, and updates a bank of parameter registers. The registers drive the `per`, `p1wid`, `del`, `p2wid`, `p1wid2`, `del2`, `p2wid2`, `p1st2`, `nut_w`, `nut_d`, `pr_att`, `cp` and `bl` inputs of the pulse generator. The block runs in the 12 MHz `clk` domain, which is the domain the pulse generator uses to register its parameters.

---
 rtl/pulse_param_rx.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pulse_param_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_param_rx.sv
// UART (8N1) command receiver that loads the pulse generator's timing parameters
// from checksummed 7-byte write frames: A5, addr, d0..d3, chk.
module pulse_param_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT      = 12000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rxd,
    output logic [31:0] per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic [15:0] p1wid2,
    output logic [15:0] del2,
    output logic [15:0] p2wid2,
    output logic [15:0] p1st2,
    output logic [7:0]  nut_w,
    output logic [15:0] nut_d,
    output logic [6:0]  pr_att,
    output logic        cp,
    output logic        bl,
    output logic        upd,
    output logic        err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] MAX_ADDR  = 8'h0C;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_SYNC, P_ADDR, P_D0, P_D1, P_D2, P_D3, P_CHK} p_state_t;

    // ---------------- input synchronizer ----------------
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rxd;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // ---------------- UART byte receiver ----------------
    rx_state_t      rx_state_reg;
    logic [CW-1:0]  bit_cnt_reg;
    logic [2:0]     bit_idx_reg;
    logic [7:0]     shift_reg;
    logic [7:0]     byte_reg;
    logic           byte_valid_reg;
    logic           bit_tick;
    logic           half_tick;
    logic           stop_fail;

    assign bit_tick  = (bit_cnt_reg == CW'(CLKS_PER_BIT - 1));
    assign half_tick = (bit_cnt_reg == CW'(HALF - 1));
    // Framing error is seen by the parser on the stop-sample edge itself.
    assign stop_fail = (rx_state_reg == RX_STOP) && bit_tick && !rx_sync_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state_reg   <= RX_IDLE;
            bit_cnt_reg    <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_reg       <= '0;
            byte_valid_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    bit_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg)
                        rx_state_reg <= RX_START;
                end
                RX_START: begin
                    if (half_tick) begin
                        bit_cnt_reg  <= '0;
                        bit_idx_reg  <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        bit_cnt_reg <= '0;
                        shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7)
                            rx_state_reg <= RX_STOP;
                        else
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_tick) begin
                        bit_cnt_reg  <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (rx_sync_reg) begin
                            byte_reg       <= shift_reg;
                            byte_valid_reg <= 1'b1;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ---------------- frame parser ----------------
    p_state_t       p_state_reg;
    logic [7:0]     addr_reg;
    logic [31:0]    data_reg;
    logic [7:0]     xor_reg;
    logic [TW-1:0]  idle_cnt_reg;
    logic           upd_reg;
    logic           err_reg;
    logic           chk_ok;
    logic           wr_fire;
    logic           timeout_hit;

    assign chk_ok      = (byte_reg == xor_reg) && (addr_reg <= MAX_ADDR);
    assign wr_fire     = byte_valid_reg && (p_state_reg == P_CHK) && chk_ok;
    assign timeout_hit = (p_state_reg != P_SYNC) && (idle_cnt_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_state_reg  <= P_SYNC;
            addr_reg     <= '0;
            data_reg     <= '0;
            xor_reg      <= '0;
            idle_cnt_reg <= '0;
            upd_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            err_reg <= 1'b0;
            if (stop_fail) begin
                p_state_reg  <= P_SYNC;
                idle_cnt_reg <= '0;
                err_reg      <= 1'b1;
            end else if (byte_valid_reg) begin
                idle_cnt_reg <= '0;
                case (p_state_reg)
                    P_SYNC: if (byte_reg == SYNC_BYTE) p_state_reg <= P_ADDR;
                    P_ADDR: begin
                        addr_reg    <= byte_reg;
                        xor_reg     <= byte_reg;
                        p_state_reg <= P_D0;
                    end
                    P_D0: begin
                        data_reg[7:0] <= byte_reg;
                        xor_reg       <= xor_reg ^ byte_reg;
                        p_state_reg   <= P_D1;
                    end
                    P_D1: begin
                        data_reg[15:8] <= byte_reg;
                        xor_reg        <= xor_reg ^ byte_reg;
                        p_state_reg    <= P_D2;
                    end
                    P_D2: begin
                        data_reg[23:16] <= byte_reg;
                        xor_reg         <= xor_reg ^ byte_reg;
                        p_state_reg     <= P_D3;
                    end
                    P_D3: begin
                        data_reg[31:24] <= byte_reg;
                        xor_reg         <= xor_reg ^ byte_reg;
                        p_state_reg     <= P_CHK;
                    end
                    P_CHK: begin
                        if (chk_ok) upd_reg <= 1'b1;
                        else        err_reg <= 1'b1;
                        p_state_reg <= P_SYNC;
                    end
                    default: p_state_reg <= P_SYNC;
                endcase
            end else if (p_state_reg != P_SYNC) begin
                // Stalled partial frame: abandon it once the line stays quiet too long.
                if (timeout_hit) begin
                    p_state_reg  <= P_SYNC;
                    idle_cnt_reg <= '0;
                    err_reg      <= 1'b1;
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + TW'(1);
                end
            end
        end
    end

    // ---------------- parameter register bank ----------------
    logic [12:0]      wr_sel;
    logic [6:0][15:0] t16_q;
    logic [31:0]      per_reg;
    logic [7:0]       nut_w_reg;
    logic [15:0]      nut_d_reg;
    logic [6:0]       pr_att_reg;
    logic             cp_reg;
    logic             bl_reg;

    generate
        for (genvar gi = 0; gi < 13; gi++) begin : g_dec
            assign wr_sel[gi] = wr_fire && (addr_reg == 8'(gi));
        end
        // Addresses 0x01..0x07 are the seven 16-bit timing registers.
        for (genvar gi = 0; gi < 7; gi++) begin : g_t16
            logic [15:0] val_reg;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    val_reg <= '0;
                else if (wr_sel[gi + 1])
                    val_reg <= data_reg[15:0];
            end
            assign t16_q[gi] = val_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            per_reg    <= 32'd10000;
            nut_w_reg  <= '0;
            nut_d_reg  <= '0;
            pr_att_reg <= '0;
            cp_reg     <= 1'b0;
            bl_reg     <= 1'b0;
        end else begin
            if (wr_sel[0])  per_reg    <= data_reg;
            if (wr_sel[8])  nut_w_reg  <= data_reg[7:0];
            if (wr_sel[9])  nut_d_reg  <= data_reg[15:0];
            if (wr_sel[10]) pr_att_reg <= data_reg[6:0];
            if (wr_sel[11]) cp_reg     <= data_reg[0];
            if (wr_sel[12]) bl_reg     <= data_reg[0];
        end
    end

    assign per    = per_reg;
    assign p1wid  = t16_q[0];
    assign del    = t16_q[1];
    assign p2wid  = t16_q[2];
    assign p1wid2 = t16_q[3];
    assign del2   = t16_q[4];
    assign p2wid2 = t16_q[5];
    assign p1st2  = t16_q[6];
    assign nut_w  = nut_w_reg;
    assign nut_d  = nut_d_reg;
    assign pr_att = pr_att_reg;
    assign cp     = cp_reg;
    assign bl     = bl_reg;
    assign upd    = upd_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_pulse_param_rx.sv
// Directed bench for pulse_param_rx: UART frames driven bit by bit, expected values hand-computed.
module tb_pulse_param_rx;

    localparam int CPB  = 64;
    localparam int TO   = 1000;
    localparam int HALF = CPB / 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rxd;
    logic [31:0] per;
    logic [15:0] p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [6:0]  pr_att;
    logic        cp, bl, upd, err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int upd_total = 0, err_total = 0;
    int upd_last = -1, err_last = -1;
    int last_start = 0;

    pulse_param_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .rxd(rxd),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .p1wid2(p1wid2), .del2(del2), .p2wid2(p2wid2), .p1st2(p1st2),
        .nut_w(nut_w), .nut_d(nut_d), .pr_att(pr_att), .cp(cp), .bl(bl),
        .upd(upd), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (upd) begin upd_total <= upd_total + 1; upd_last <= cyc; end
        if (err) begin err_total <= err_total + 1; err_last <= cyc; end
    end

    function automatic logic [176:0] pack_regs();
        return {per, p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_w, nut_d, pr_att, cp, bl};
    endfunction

    // Called right after a negedge; returns on a negedge with the line idle.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        last_start = cyc;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [55:0] f);
        for (int i = 6; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
        repeat (10) @(negedge clk);
        $display("frame %014h sent at cycle %0d", f, cyc);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (per !== 32'd10000) begin errors++; $display("FAIL reset_per: got %0d want 10000", per); end
        checks++; if ({p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_w, nut_d, pr_att, cp, bl} !== '0) begin
            errors++; $display("FAIL reset_others: got nonzero register, want all 0"); end
        checks++; if (upd !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_strobes: upd=%b err=%b want 0 0", upd, err); end
        resetn = 1'b1;
        repeat (2000) @(negedge clk);
        checks++; if (upd_total !== 0) begin errors++; $display("FAIL idle_upd: got %0d pulses want 0", upd_total); end
        checks++; if (err_total !== 0) begin errors++; $display("FAIL idle_err: got %0d pulses want 0", err_total); end
        checks++; if (per !== 32'd10000) begin errors++; $display("FAIL idle_per: got %0d want 10000", per); end
        $display("reset test done at cycle %0d", cyc);
    endtask

    task automatic test_valid_write();
        int u0, e0, exp_cyc;
        u0 = upd_total; e0 = err_total;
        send_frame(56'hA5_00_20_4E_00_00_6E);
        exp_cyc = last_start + 4 + HALF + 9 * CPB;
        checks++; if (per !== 32'h0000_4E20) begin errors++; $display("FAIL write_per: got %h want 00004e20", per); end
        checks++; if (upd_total - u0 !== 1) begin errors++; $display("FAIL write_upd_count: got %0d want 1", upd_total - u0); end
        checks++; if (upd_last !== exp_cyc) begin errors++; $display("FAIL write_upd_time: got cycle %0d want %0d", upd_last, exp_cyc); end
        checks++; if (err_total - e0 !== 0) begin errors++; $display("FAIL write_err: got %0d want 0", err_total - e0); end
        checks++; if ({p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_w, nut_d, pr_att, cp, bl} !== '0) begin
            errors++; $display("FAIL write_others: other register changed, want all 0"); end
    endtask

    task automatic test_checksum();
        int u0, e0;
        u0 = upd_total; e0 = err_total;
        send_frame(56'hA5_01_3C_00_00_00_00);
        checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL badchk_err: got %0d want 1", err_total - e0); end
        checks++; if (upd_total - u0 !== 0) begin errors++; $display("FAIL badchk_upd: got %0d want 0", upd_total - u0); end
        checks++; if (p1wid !== 16'd0) begin errors++; $display("FAIL badchk_p1wid: got %0d want 0", p1wid); end
        send_frame(56'hA5_01_3C_00_00_00_3D);
        checks++; if (p1wid !== 16'd60) begin errors++; $display("FAIL goodchk_p1wid: got %0d want 60", p1wid); end
        checks++; if (upd_total - u0 !== 1) begin errors++; $display("FAIL goodchk_upd: got %0d want 1", upd_total - u0); end
    endtask

    task automatic test_trunc_addr();
        int u0, e0;
        logic [176:0] snap;
        u0 = upd_total; e0 = err_total;
        send_frame(56'hA5_0A_FF_00_00_00_F5);
        checks++; if (pr_att !== 7'h7F) begin errors++; $display("FAIL trunc_pr_att: got %h want 7f", pr_att); end
        checks++; if (upd_total - u0 !== 1 || err_total - e0 !== 0) begin
            errors++; $display("FAIL trunc_strobes: upd %0d err %0d want 1 0", upd_total - u0, err_total - e0); end
        snap = pack_regs();
        u0 = upd_total; e0 = err_total;
        send_frame(56'hA5_0D_01_00_00_00_0C);
        checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL badaddr_err: got %0d want 1", err_total - e0); end
        checks++; if (upd_total - u0 !== 0) begin errors++; $display("FAIL badaddr_upd: got %0d want 0", upd_total - u0); end
        checks++; if (pack_regs() !== snap) begin errors++; $display("FAIL badaddr_regs: got %h want %h", pack_regs(), snap); end
    endtask

    task automatic test_framing();
        int u0, e0, exp_cyc;
        u0 = upd_total; e0 = err_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        exp_cyc = last_start + 3 + HALF + 9 * CPB;
        repeat (20) @(negedge clk);
        $display("framing-error byte sent at cycle %0d", cyc);
        checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL framing_err: got %0d want 1", err_total - e0); end
        checks++; if (err_last !== exp_cyc) begin errors++; $display("FAIL framing_time: got cycle %0d want %0d", err_last, exp_cyc); end
        send_frame(56'hA5_02_34_12_00_00_24);
        checks++; if (del !== 16'h1234) begin errors++; $display("FAIL fresh_del: got %h want 1234", del); end
        checks++; if (upd_total - u0 !== 1 || err_total - e0 !== 1) begin
            errors++; $display("FAIL fresh_strobes: upd %0d err %0d want 1 1", upd_total - u0, err_total - e0); end
    endtask

    task automatic test_timeout();
        int u0, e0, exp_cyc;
        u0 = upd_total; e0 = err_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        exp_cyc = last_start + 4 + HALF + 9 * CPB + TO;
        repeat (TO + 50) @(negedge clk);
        $display("partial frame A5 03 timed out by cycle %0d", cyc);
        checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d want 1", err_total - e0); end
        checks++; if (err_last !== exp_cyc) begin errors++; $display("FAIL timeout_time: got cycle %0d want %0d", err_last, exp_cyc); end
        checks++; if (p2wid !== 16'd0 || upd_total - u0 !== 0) begin
            errors++; $display("FAIL timeout_nowrite: p2wid %0d upd %0d want 0 0", p2wid, upd_total - u0); end
    endtask

    task automatic test_glitch();
        int u0, e0;
        u0 = upd_total; e0 = err_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h0B, 1'b1);
        repeat (20) @(negedge clk);
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h0A, 1'b1);
        repeat (10) @(negedge clk);
        $display("glitch frame finished at cycle %0d", cyc);
        checks++; if (err_total - e0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d want 0", err_total - e0); end
        checks++; if (cp !== 1'b1) begin errors++; $display("FAIL glitch_cp: got %b want 1", cp); end
        checks++; if (upd_total - u0 !== 1) begin errors++; $display("FAIL glitch_upd: got %0d want 1", upd_total - u0); end
    endtask

    task automatic test_async_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB * 3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (per !== 32'd10000) begin errors++; $display("FAIL async_per: got %0d want 10000", per); end
        checks++; if ({p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_w, nut_d, pr_att, cp, bl} !== '0) begin
            errors++; $display("FAIL async_others: register not cleared, want all 0"); end
        checks++; if (upd !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL async_strobes: upd=%b err=%b want 0 0", upd, err); end
        @(negedge clk);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        $display("reset asserted mid-D2, released at cycle %0d", cyc);
        send_frame(56'hA5_0C_01_00_00_00_0D);
        checks++; if (bl !== 1'b1) begin errors++; $display("FAIL post_reset_bl: got %b want 1", bl); end
        checks++; if (per !== 32'd10000) begin errors++; $display("FAIL post_reset_per: got %0d want 10000", per); end
    endtask

    initial begin
        resetn = 1'b0;
        rxd = 1'b1;
        @(negedge clk);
        test_reset();
        test_valid_write();
        test_checksum();
        test_trunc_addr();
        test_framing();
        test_timeout();
        test_glitch();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
